// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller: state encoding and reset defaults.
package pwm_pkg;

    localparam int W_DEF      = 16;
    localparam int DEF_PERIOD = 10;
    localparam int DEF_DUTY   = 3;
    // Smallest period the generator can run with (one high and one low clock).
    localparam int MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Configuration port of the PWM ramp controller: valid/ready transfer of a
// new period and target high-time.
interface pwm_ramp_ctrl_if
    import pwm_pkg::*;
#(
    parameter int W = W_DEF
) ();

    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_duty;

    modport master (output cfg_valid, output cfg_period, output cfg_duty, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_period, input cfg_duty, output cfg_ready);

endinterface

// File: rtl/pwm_step_timer.sv
// Counts PWM period boundaries and flags the STEP_DIV-th one, which is when the
// ramp takes its next step. The count restarts after each step and on clr.
module pwm_step_timer
    import pwm_pkg::*;
#(
    parameter int STEP_DIV = 4   // >= 1
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clr,
    input  logic pulse,
    output logic tc
);

    localparam int            CW     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = pulse && (cnt_q == TC_VAL);

    // Next count: clear wins, otherwise advance on each counted boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || tc) begin
            cnt_d = '0;
        end else if (pulse) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Sequencer for the single-channel PWM generator: shadow config registers,
// soft-start / soft-stop duty ramp, and boundary-aligned output updates.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | generator disabled, waiting for start
// RAMP_UP   | high-time stepping up toward target
// HOLD      | at target; shadow config applied at each period boundary
// RAMP_DOWN | high-time stepping down toward target, or toward 0 when stopping
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int W          = pwm_pkg::W_DEF,
    parameter int DEF_PERIOD = pwm_pkg::DEF_PERIOD,
    parameter int DEF_DUTY   = pwm_pkg::DEF_DUTY,
    parameter int STEP       = 1,
    parameter int STEP_DIV   = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic             stop,
    input  logic             period_boundary,
    pwm_ramp_ctrl_if.slave   cfg,
    output logic             pwm_en,
    output logic [W-1:0]     period_out,
    output logic [W-1:0]     h_time_out,
    output logic             busy,
    output logic             done
);

    localparam int AW = W + 1;

    state_t         state_q, state_d;
    logic           pwm_en_q, pwm_en_d;
    logic [W-1:0]   period_q, period_d;
    logic [W-1:0]   h_q, h_d;
    logic [W-1:0]   shadow_q, shadow_d;
    logic [W-1:0]   target_q, target_d;
    logic           stopping_q, stopping_d;
    logic           done_q, done_d;
    logic           restart;

    logic           step_pulse, step_tc, step_clr;
    logic           accept;
    logic [W-1:0]   goal, cfg_per_clamp, cfg_duty_clamp;
    logic [W:0]     up_sum, dn_floor, h_up, h_dn;

    assign cfg.cfg_ready = (state_q == IDLE) || (state_q == HOLD);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;

    assign cfg_per_clamp  = (cfg.cfg_period < W'(MIN_PERIOD)) ? W'(MIN_PERIOD) : cfg.cfg_period;
    assign cfg_duty_clamp = (cfg.cfg_duty > cfg_per_clamp) ? cfg_per_clamp : cfg.cfg_duty;

    // One extra bit keeps the step sums from wrapping; results clamp at the goal.
    assign goal     = stopping_q ? '0 : target_q;
    assign up_sum   = {1'b0, h_q} + AW'(STEP);
    assign dn_floor = {1'b0, goal} + AW'(STEP);
    assign h_up     = (up_sum >= {1'b0, target_q}) ? {1'b0, target_q} : up_sum;
    assign h_dn     = ({1'b0, h_q} >= dn_floor) ? ({1'b0, h_q} - AW'(STEP)) : {1'b0, goal};

    assign step_pulse = period_boundary && ((state_q == RAMP_UP) || (state_q == RAMP_DOWN));
    assign step_clr   = (state_d != state_q) || restart;

    pwm_step_timer #(.STEP_DIV(STEP_DIV)) u_step_timer (
        .clk     (clk),
        .n_reset (n_reset),
        .clr     (step_clr),
        .pulse   (step_pulse),
        .tc      (step_tc)
    );

    // Next state and output values; stop outranks a ramp step or config apply.
    always_comb begin
        state_d    = state_q;
        pwm_en_d   = pwm_en_q;
        period_d   = period_q;
        h_d        = h_q;
        stopping_d = stopping_q;
        done_d     = 1'b0;
        restart    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    pwm_en_d = 1'b1;
                    period_d = shadow_q;
                    h_d      = '0;
                    if (target_q == '0) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RAMP_UP;
                    end
                end
            end
            RAMP_UP: begin
                if (stop) begin
                    state_d    = RAMP_DOWN;
                    stopping_d = 1'b1;
                end else if (step_tc) begin
                    h_d = h_up[W-1:0];
                    if (h_up == {1'b0, target_q}) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d    = RAMP_DOWN;
                    stopping_d = 1'b1;
                end else if (period_boundary) begin
                    period_d = shadow_q;
                    if (target_q > h_q) begin
                        state_d = RAMP_UP;
                    end else if (target_q < h_q) begin
                        state_d = RAMP_DOWN;
                    end
                end
            end
            RAMP_DOWN: begin
                if (stop && !stopping_q) begin
                    // Retarget a ramp-down-to-duty into a full soft-stop.
                    stopping_d = 1'b1;
                    restart    = 1'b1;
                end else if (step_tc) begin
                    h_d = h_dn[W-1:0];
                    if (h_dn == {1'b0, goal}) begin
                        done_d = 1'b1;
                        if (stopping_q) begin
                            state_d    = IDLE;
                            pwm_en_d   = 1'b0;
                            h_d        = '0;
                            stopping_d = 1'b0;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shadow registers capture an accepted config; a later accept overwrites it.
    always_comb begin
        shadow_d = shadow_q;
        target_d = target_q;
        if (accept) begin
            shadow_d = cfg_per_clamp;
            target_d = cfg_duty_clamp;
        end
    end

    // State, output and shadow registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            pwm_en_q   <= 1'b0;
            period_q   <= W'(DEF_PERIOD);
            h_q        <= '0;
            shadow_q   <= W'(DEF_PERIOD);
            target_q   <= W'(DEF_DUTY);
            stopping_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pwm_en_q   <= pwm_en_d;
            period_q   <= period_d;
            h_q        <= h_d;
            shadow_q   <= shadow_d;
            target_q   <= target_d;
            stopping_q <= stopping_d;
            done_q     <= done_d;
        end
    end

    assign pwm_en     = pwm_en_q;
    assign period_out = period_q;
    assign h_time_out = h_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule
